core2axi_pipe: RTL

Parametrised, pipelined successor to the single-outstanding core-to-AXI bridge: converts the core data-port request/grant/rvalid protocol into AXI4 single-beat transactions. Supports a configurable AXI data width, up to MAX_OUTSTANDING in-flight transactions of one direction, independent AW/W handshakes, and correct byte-lane steering. Sits between a core LSU (or a debug/DMA master using the same port) and the SoC AXI interconnect.

---
 rtl/core2axi_pipe_pkg.sv | 26 ++
 rtl/core2axi_track_fifo.sv | 59 +++++
 rtl/core2axi_pipe.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/core2axi_pipe_pkg.sv
// Shared types and AXI constants for the pipelined core-to-AXI bridge.
package core2axi_pipe_pkg;

  // Widest lane offset: a 128-bit bus has four 32-bit lanes.
  localparam int unsigned OffMaxW = 2;

  localparam logic [2:0] AxiSizeWord   = 3'b010;
  localparam logic [1:0] AxiBurstIncr  = 2'b01;
  localparam logic [1:0] AxiRespSlverr = 2'b10;
  localparam logic [1:0] AxiRespDecerr = 2'b11;

  typedef struct packed {
    logic               we;
    logic [OffMaxW-1:0] off;
  } track_entry_t;

  // Number of address bits selecting a 32-bit lane on a bus of the given width.
  function automatic int unsigned off_w(int unsigned data_width);
    return $clog2(data_width / 8) - 2;
  endfunction

  function automatic logic resp_is_err(logic [1:0] resp);
    return (resp == AxiRespSlverr) || (resp == AxiRespDecerr);
  endfunction

endpackage

// File: rtl/core2axi_track_fifo.sv
// Synchronous FIFO of in-flight transactions with head and tail peek.
module core2axi_track_fifo #(
  parameter int unsigned Depth  = 4,
  parameter type         EntryT = logic
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_i,
  input  EntryT data_i,
  input  logic  pop_i,
  output EntryT head_o,
  output EntryT tail_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  EntryT           mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q, tail_ptr;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o   = (count_q == CntW'(Depth));
  assign empty_o  = (count_q == '0);
  assign do_push  = push_i & ~full_o;
  assign do_pop   = pop_i & ~empty_o;
  assign tail_ptr = (wr_ptr_q == '0) ? PtrW'(Depth - 1) : wr_ptr_q - 1'b1;
  assign head_o   = mem_q[rd_ptr_q];
  assign tail_o   = mem_q[tail_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/core2axi_pipe.sv
// Core data-port to AXI4 single-beat bridge with multiple same-direction transactions in flight.
// Define CORE2AXI_PIPE_ERR_EN to report SLVERR/DECERR responses on data_err_o.
module core2axi_pipe
  import core2axi_pipe_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_DATA_WIDTH  = 64,
  parameter int unsigned AXI_ID_WIDTH    = 4,
  parameter int unsigned AXI_ID          = 0,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  // Core data port
  input  logic                        data_req_i,
  output logic                        data_gnt_o,
  output logic                        data_rvalid_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                        data_we_i,
  input  logic [3:0]                  data_be_i,
  input  logic [31:0]                 data_wdata_i,
  output logic [31:0]                 data_rdata_o,
  output logic                        data_err_o,
  // AXI write address
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
  output logic [7:0]                  aw_len_o,
  output logic [2:0]                  aw_size_o,
  output logic [1:0]                  aw_burst_o,
  output logic                        aw_lock_o,
  output logic [3:0]                  aw_cache_o,
  output logic [2:0]                  aw_prot_o,
  output logic [3:0]                  aw_qos_o,
  output logic [3:0]                  aw_region_o,
  output logic                        aw_user_o,
  // AXI write data
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
  output logic                        w_last_o,
  output logic                        w_user_o,
  // AXI write response
  input  logic                        b_valid_i,
  output logic                        b_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     b_id_i,
  input  logic [1:0]                  b_resp_i,
  // AXI read address
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]     ar_id_o,
  output logic [7:0]                  ar_len_o,
  output logic [2:0]                  ar_size_o,
  output logic [1:0]                  ar_burst_o,
  output logic                        ar_lock_o,
  output logic [3:0]                  ar_cache_o,
  output logic [2:0]                  ar_prot_o,
  output logic [3:0]                  ar_qos_o,
  output logic [3:0]                  ar_region_o,
  output logic                        ar_user_o,
  // AXI read data
  input  logic                        r_valid_i,
  output logic                        r_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     r_id_i,
  input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]                  r_resp_i,
  input  logic                        r_last_i
);

  localparam int unsigned NumLanes = AXI_DATA_WIDTH / 32;
  localparam logic [OffMaxW-1:0] LaneMask = OffMaxW'((1 << off_w(AXI_DATA_WIDTH)) - 1);

  typedef enum logic [1:0] {WrIdle, WrAwOnly, WrWOnly} wr_state_e;

  wr_state_e          wr_state_q, wr_state_d;
  track_entry_t       head, tail, push_entry;
  logic               fifo_full, fifo_empty, push, pop;
  logic [OffMaxW-1:0] req_off;
  logic               allowed, rd_gnt, wr_gnt, aw_hs, w_hs, r_hs, b_hs;
  logic               aw_done, w_done;
  logic               rvalid_q;
  logic [31:0]        rdata_q, r_lane;
  logic               unused_in;

  assign req_off = data_addr_i[3:2] & LaneMask;

  // Reads and writes are never mixed in flight: AXI does not order them against each other.
  assign allowed = ~rst & data_req_i & ~fifo_full & (fifo_empty | (tail.we == data_we_i));

  // WrAwOnly: W already accepted, AW still pending; WrWOnly is the reverse.
  assign aw_done = (wr_state_q == WrWOnly);
  assign w_done  = (wr_state_q == WrAwOnly);

  assign ar_valid_o = allowed & ~data_we_i;
  assign aw_valid_o = allowed & data_we_i & ~aw_done;
  assign w_valid_o  = allowed & data_we_i & ~w_done;

  assign aw_hs  = aw_valid_o & aw_ready_i;
  assign w_hs   = w_valid_o & w_ready_i;
  assign rd_gnt = ar_valid_o & ar_ready_i;
  assign wr_gnt = allowed & data_we_i & (aw_done | aw_hs) & (w_done | w_hs);

  assign data_gnt_o = rd_gnt | wr_gnt;
  assign push       = data_gnt_o;
  assign push_entry = '{we: data_we_i, off: req_off};

  always_comb begin
    wr_state_d = wr_state_q;
    if (wr_gnt) begin
      wr_state_d = WrIdle;
    end else if (aw_hs) begin
      wr_state_d = WrWOnly;
    end else if (w_hs) begin
      wr_state_d = WrAwOnly;
    end
  end

  assign aw_addr_o   = data_addr_i;
  assign aw_id_o     = AXI_ID_WIDTH'(AXI_ID);
  assign aw_len_o    = 8'd0;
  assign aw_size_o   = AxiSizeWord;
  assign aw_burst_o  = AxiBurstIncr;
  assign aw_lock_o   = 1'b0;
  assign aw_cache_o  = 4'd0;
  assign aw_prot_o   = 3'd0;
  assign aw_qos_o    = 4'd0;
  assign aw_region_o = 4'd0;
  assign aw_user_o   = 1'b0;

  assign ar_addr_o   = data_addr_i;
  assign ar_id_o     = AXI_ID_WIDTH'(AXI_ID);
  assign ar_len_o    = 8'd0;
  assign ar_size_o   = AxiSizeWord;
  assign ar_burst_o  = AxiBurstIncr;
  assign ar_lock_o   = 1'b0;
  assign ar_cache_o  = 4'd0;
  assign ar_prot_o   = 3'd0;
  assign ar_qos_o    = 4'd0;
  assign ar_region_o = 4'd0;
  assign ar_user_o   = 1'b0;

  assign w_data_o = {NumLanes{data_wdata_i}};
  assign w_last_o = 1'b1;
  assign w_user_o = 1'b0;

  always_comb begin
    w_strb_o = '0;
    for (int unsigned i = 0; i < NumLanes; i++) begin
      if (req_off == OffMaxW'(i)) w_strb_o[4*i +: 4] = data_be_i;
    end
  end

  core2axi_track_fifo #(
    .Depth  (MAX_OUTSTANDING),
    .EntryT (track_entry_t)
  ) u_track_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .tail_o  (tail),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign r_ready_o = ~rst & ~fifo_empty & ~head.we;
  assign b_ready_o = ~rst & ~fifo_empty & head.we;
  assign r_hs      = r_valid_i & r_ready_o;
  assign b_hs      = b_valid_i & b_ready_o;
  assign pop       = r_hs | b_hs;

  always_comb begin
    r_lane = r_data_i[31:0];
    for (int unsigned i = 1; i < NumLanes; i++) begin
      if (head.off == OffMaxW'(i)) r_lane = r_data_i[32*i +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WrIdle;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rvalid_q   <= pop;
      if (r_hs) rdata_q <= r_lane;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;

`ifdef CORE2AXI_PIPE_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (r_hs & resp_is_err(r_resp_i)) | (b_hs & resp_is_err(b_resp_i));
    end
  end

  assign data_err_o = err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{r_resp_i, b_resp_i};
  assign data_err_o  = 1'b0;
`endif

  assign unused_in = ^{r_id_i, b_id_i, r_last_i, tail.off};

endmodule
